caseg_scan_capture: RTL and testbench
=====================================

// Module: caseg_scan_capture
// PURPOSE
//  Receive-side monitor for the common-anode 8-digit multiplexed display bus (sel/seg).
//  Samples each scanned digit once sel/seg have settled and decodes the segment pattern back to a digit code.
//  Publishes a coherent 8-digit frame once every digit has been captured.
//  Sits beside the display driver for self-check/loopback, or on board pins to read a display.
// PARAMETERS
//  SETTLE_CYC     4          cycles sel/seg must stay unchanged before a sample is taken (>=1)
//  FRAME_TIMEOUT  1_000_000  cycles without completing a frame before partial capture is discarded
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  sel          in   8   digit select, active-low one-hot; sel[i]=0 -> digit i lit
//  seg          in   8   segments, active-low; seg[6:0]=g..a, seg[7]=dp
//  bit_7..bit_0 out  4   captured digit codes of last complete frame
//  dp           out  8   captured decimal points of last frame, 1 = lit
//  frame_valid  out  1   1-cycle pulse when bit_*/dp update
//  seg_err      out  1   sticky: an unrecognised pattern was sampled; cleared by rst only
//  timeout      out  1   1-cycle pulse when a partial frame is discarded
// BEHAVIOUR
//  Reset: bit_* = 4'hA (blank), dp = 0, frame_valid = 0, seg_err = 0, timeout = 0.
//  Reset: shadow regs = 4'hA, seen mask = 0, counters = 0, FSM = WAIT.
//  Inputs pass through a 2-flop synchroniser; all timing below is counted from the synchronised values.
//  FSM WAIT: {sel,seg} differs from last cycle -> stable_cnt = 0, stay.
//  FSM WAIT: otherwise stable_cnt++; reaching SETTLE_CYC with sel valid -> SAMPLE.
//  sel is valid only if exactly one bit is 0; zero or several low bits never sample, stay WAIT.
//  FSM SAMPLE (1 cycle): decode seg[6:0] into shadow[i] for the low bit i; dp_shadow[i] = ~seg[7]; seen[i] = 1; -> HOLD.
//  FSM HOLD: stay until {sel,seg} changes, then WAIT with stable_cnt = 0.
//  The HOLD rule gives exactly one sample per scan slot.
//  Decode map, seg[6:0] -> code:
//   7'h40->0  79->1  24->2  30->3  19->4  12->5  02->6  78->7  00->8  10->9  7F->4'hA (blank)
//   any other pattern -> 4'hF and seg_err set.
//  Resampling a digit already in seen overwrites shadow (last value wins).
//  Frame: seen == 8'hFF at end of a cycle ->
//   - bit_*/dp load from shadow in the next cycle, with frame_valid high that same cycle;
//   - seen clears;
//   - a SAMPLE in that same cycle sets its bit in the new, cleared mask.
//  Latency: last digit's SAMPLE cycle + 1 to frame_valid.
//  Outputs hold between frames.
//  Timeout: frame_cnt counts cycles since the last frame_valid or timeout.
//   - At FRAME_TIMEOUT-1: seen clears, timeout pulses 1 cycle, frame_cnt restarts.
//   - Outputs are unchanged.
//   - Timeout and frame completion in the same cycle: completion wins, no timeout pulse.
//  rst mid-operation: discards shadow and seen immediately; resumes from WAIT.
//  Counter widths: $clog2(param+1); no wrap (saturate at terminal value).
// CONFIGURATION
//  CASEG_TIME_DECODE_EN defined: adds outputs hour, minute, second (6 bits each, binary) and time_err (1).
//   - On each frame_valid: hour = bit_5*10+bit_4, minute = bit_3*10+bit_2, second = bit_1*10+bit_0.
//   - time_err = 1 if any of those digits > 9, hour > 23, minute > 59 or second > 59;
//     in that case hour/minute/second hold their previous values.
//   - Reset: hour/minute/second = 0, time_err = 0.
//   - Updates coincide with bit_* (same latency).
//  CASEG_TIME_DECODE_EN undefined: these ports and their logic do not exist.
// TESTING
//  1 Scan "12:34:56" as digits 7..0 = blank,blank,1,2,3,4,5,6, 50 cycles per digit, SETTLE_CYC=4
//    -> frame_valid once per 8 digits; bit_5=1, bit_0=6; bit_7=A; seg_err=0.
//  2 Glitch: seg toggles every 2 cycles for 10 cycles on one digit, then stable
//    -> no sample during glitch; single sample of the stable value.
//  3 sel=8'hFC (two digits low) held 100 cycles -> no sample, seen unchanged, no frame_valid.
//  4 Scan digits 0..5 only, FRAME_TIMEOUT=1000 -> timeout pulse at cycle 999 after reset.
//    Outputs stay at reset values; a later full scan yields a frame.
//  5 seg[6:0]=7'h7E on digit 3 -> bit_3=F after frame; seg_err stays 1 through later good frames.
//  6 (CASEG_TIME_DECODE_EN) frame 23:59:59 -> hour=23, minute=59, second=59.
//    Next frame 24:00:00 -> time_err=1, hour stays 23.

Source files
------------

// File: rtl/caseg_scan_capture.sv
// Receive-side capture of a multiplexed 8-digit common-anode display bus (sel/seg).
// Optional clock decode of digits 5..0 is enabled with `define CASEG_TIME_DECODE_EN.
module caseg_scan_capture #(
    parameter int SETTLE_CYC    = 4,
    parameter int FRAME_TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sel,
    input  logic [7:0] seg,
    output logic [3:0] bit_7,
    output logic [3:0] bit_6,
    output logic [3:0] bit_5,
    output logic [3:0] bit_4,
    output logic [3:0] bit_3,
    output logic [3:0] bit_2,
    output logic [3:0] bit_1,
    output logic [3:0] bit_0,
    output logic [7:0] dp,
    output logic       frame_valid,
    output logic       seg_err,
    output logic       timeout
`ifdef CASEG_TIME_DECODE_EN
    ,
    output logic [5:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic       time_err
`endif
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int FW = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC);
    localparam logic [FW-1:0] TMO_LAST    = FW'(FRAME_TIMEOUT - 1);

    typedef enum logic [1:0] {ST_WAIT, ST_SAMPLE, ST_HOLD} state_t;

    state_t          state_q, state_d;
    logic [15:0]     sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [SW-1:0]   stable_cnt_q, stable_cnt_d;
    logic [7:0][3:0] shadow_q, shadow_d;
    logic [7:0]      dps_q, dps_d;
    logic [7:0]      seen_q, seen_d;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [7:0][3:0] out_q, out_d;
    logic [7:0]      dp_q, dp_d;
    logic            frame_valid_q, frame_valid_d;
    logic            seg_err_q, seg_err_d;
    logic            timeout_q, timeout_d;

    logic       changed, sel_ok, do_sample, code_bad, complete, tmo;
    logic [3:0] code;
    logic [7:0] sample_sel, seen_set;
    logic [FW-1:0] frame_cnt_inc;

    always_comb begin
        sync1_d = {sel, seg};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    assign changed    = (sync2_q != prev_q);
    assign sel_ok     = ($countones(~sync2_q[15:8]) == 1);
    // prev_q holds the value that met the settle window, even if the bus moves during SAMPLE
    assign sample_sel = ~prev_q[15:8];

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_WAIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        stable_cnt_d = stable_cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (changed) begin
                    stable_cnt_d = '0;
                end else begin
                    if (stable_cnt_q < SETTLE_LAST) stable_cnt_d = stable_cnt_q + 1'b1;
                    if (stable_cnt_d >= SETTLE_LAST && sel_ok) state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (changed) begin
                    state_d      = ST_WAIT;
                    stable_cnt_d = '0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (changed) begin
                    state_d      = ST_WAIT;
                    stable_cnt_d = '0;
                end
            end
            default: begin
                state_d      = ST_WAIT;
                stable_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        do_sample = (state_q == ST_SAMPLE);
        code_bad  = 1'b0;
        case (prev_q[6:0])
            7'h40:   code = 4'd0;
            7'h79:   code = 4'd1;
            7'h24:   code = 4'd2;
            7'h30:   code = 4'd3;
            7'h19:   code = 4'd4;
            7'h12:   code = 4'd5;
            7'h02:   code = 4'd6;
            7'h78:   code = 4'd7;
            7'h00:   code = 4'd8;
            7'h10:   code = 4'd9;
            7'h7F:   code = 4'hA;
            default: begin
                code     = 4'hF;
                code_bad = 1'b1;
            end
        endcase
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
        assign shadow_d[gi] = (do_sample && sample_sel[gi]) ? code : shadow_q[gi];
        assign dps_d[gi]    = (do_sample && sample_sel[gi]) ? ~prev_q[7] : dps_q[gi];
    end

    // Completion is judged on the mask including this cycle's sample, so it beats a timeout
    always_comb begin
        seen_set      = seen_q | (do_sample ? sample_sel : 8'h00);
        complete      = (seen_set == 8'hFF);
        frame_cnt_inc = (frame_cnt_q == TMO_LAST) ? frame_cnt_q : frame_cnt_q + 1'b1;
        tmo           = !complete && (frame_cnt_inc == TMO_LAST);
        seen_d        = (complete || tmo) ? 8'h00 : seen_set;
        frame_cnt_d   = (complete || tmo) ? '0 : frame_cnt_inc;
        frame_valid_d = complete;
        timeout_d     = tmo;
        out_d         = complete ? shadow_d : out_q;
        dp_d          = complete ? dps_d : dp_q;
        seg_err_d     = seg_err_q | (do_sample && code_bad);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            prev_q        <= '1;
            stable_cnt_q  <= '0;
            shadow_q      <= {8{4'hA}};
            dps_q         <= '0;
            seen_q        <= '0;
            frame_cnt_q   <= '0;
            out_q         <= {8{4'hA}};
            dp_q          <= '0;
            frame_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            stable_cnt_q  <= stable_cnt_d;
            shadow_q      <= shadow_d;
            dps_q         <= dps_d;
            seen_q        <= seen_d;
            frame_cnt_q   <= frame_cnt_d;
            out_q         <= out_d;
            dp_q          <= dp_d;
            frame_valid_q <= frame_valid_d;
            seg_err_q     <= seg_err_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bit_7       = out_q[7];
    assign bit_6       = out_q[6];
    assign bit_5       = out_q[5];
    assign bit_4       = out_q[4];
    assign bit_3       = out_q[3];
    assign bit_2       = out_q[2];
    assign bit_1       = out_q[1];
    assign bit_0       = out_q[0];
    assign dp          = dp_q;
    assign frame_valid = frame_valid_q;
    assign seg_err     = seg_err_q;
    assign timeout     = timeout_q;

`ifdef CASEG_TIME_DECODE_EN
    logic [5:0] hour_q, hour_d, minute_q, minute_d, second_q, second_d;
    logic       time_err_q, time_err_d;
    logic       digit_bad, t_bad;

    // Range checks on tens/ones digits keep the arithmetic within 6 bits
    always_comb begin
        digit_bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (shadow_d[i] > 4'd9) digit_bad = 1'b1;
        end
        t_bad = digit_bad
             || (shadow_d[5] > 4'd2) || (shadow_d[5] == 4'd2 && shadow_d[4] > 4'd3)
             || (shadow_d[3] > 4'd5) || (shadow_d[1] > 4'd5);
        hour_d     = hour_q;
        minute_d   = minute_q;
        second_d   = second_q;
        time_err_d = time_err_q;
        if (complete) begin
            time_err_d = t_bad;
            if (!t_bad) begin
                hour_d   = {2'b00, shadow_d[5]} * 6'd10 + {2'b00, shadow_d[4]};
                minute_d = {2'b00, shadow_d[3]} * 6'd10 + {2'b00, shadow_d[2]};
                second_d = {2'b00, shadow_d[1]} * 6'd10 + {2'b00, shadow_d[0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hour_q     <= '0;
            minute_q   <= '0;
            second_q   <= '0;
            time_err_q <= 1'b0;
        end else begin
            hour_q     <= hour_d;
            minute_q   <= minute_d;
            second_q   <= second_d;
            time_err_q <= time_err_d;
        end
    end

    assign hour     = hour_q;
    assign minute   = minute_q;
    assign second   = second_q;
    assign time_err = time_err_q;
`endif

endmodule

// File: tb/tb_caseg_scan_capture.sv
// Scoreboard bench: a digit-level model predicts each frame; a monitor checks every frame_valid.
module tb_caseg_scan_capture;
    localparam int SETTLE = 4;
    localparam int TMO    = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sel = 8'hFF;
    logic [7:0] seg = 8'hFF;
    logic [3:0] bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0;
    logic [7:0] dp;
    logic       frame_valid, seg_err, timeout;
`ifdef CASEG_TIME_DECODE_EN
    logic [5:0] hour, minute, second;
    logic       time_err;
`endif

    always #5 clk = ~clk;

    caseg_scan_capture #(.SETTLE_CYC(SETTLE), .FRAME_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .sel(sel), .seg(seg),
        .bit_7(bit_7), .bit_6(bit_6), .bit_5(bit_5), .bit_4(bit_4),
        .bit_3(bit_3), .bit_2(bit_2), .bit_1(bit_1), .bit_0(bit_0),
        .dp(dp), .frame_valid(frame_valid), .seg_err(seg_err), .timeout(timeout)
`ifdef CASEG_TIME_DECODE_EN
        , .hour(hour), .minute(minute), .second(second), .time_err(time_err)
`endif
    );

    wire [31:0] all_bits = {bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0};

    typedef struct {
        logic [31:0] bits;
        logic [7:0]  dp;
        logic        err;
        int          h, m, s;
        logic        terr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0, n_pass = 0, n_frames = 0, n_pushed = 0, n_tmo = 0, tmo_cyc = -1;
    int   cyc = 0;

    logic [6:0] pat_tab [11] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                 7'h02, 7'h78, 7'h00, 7'h10, 7'h7F};

    // Reference model: what each digit currently holds and which digits have been seen
    logic [3:0] m_shadow [8];
    logic [7:0] m_dp, m_seen;
    logic       m_err, m_terr;
    int         m_h, m_m, m_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic model_reset();
        for (int j = 0; j < 8; j++) m_shadow[j] = 4'hA;
        m_dp = 8'h00; m_seen = 8'h00; m_err = 1'b0;
        m_h = 0; m_m = 0; m_s = 0; m_terr = 1'b0;
    endtask

    task automatic model_sample(input int d, input logic [6:0] p, input logic dpb);
        exp_t e;
        logic [3:0] c;
        int hh, mm, ss;
        bit bad;
        c = 4'hF;
        for (int k = 0; k < 11; k++) if (pat_tab[k] == p) c = k[3:0];
        if (c == 4'hF) m_err = 1'b1;
        m_shadow[d] = c;
        m_dp[d]     = dpb;
        m_seen[d]   = 1'b1;
        if (m_seen == 8'hFF) begin
            for (int j = 0; j < 8; j++) e.bits[4*j +: 4] = m_shadow[j];
            hh = m_shadow[5] * 10 + m_shadow[4];
            mm = m_shadow[3] * 10 + m_shadow[2];
            ss = m_shadow[1] * 10 + m_shadow[0];
            bad = (hh > 23) || (mm > 59) || (ss > 59);
            for (int j = 0; j < 6; j++) if (m_shadow[j] > 9) bad = 1'b1;
            if (!bad) begin m_h = hh; m_m = mm; m_s = ss; end
            m_terr = bad;
            e.dp = m_dp; e.err = m_err; e.h = m_h; e.m = m_m; e.s = m_s; e.terr = m_terr;
            exp_q.push_back(e);
            n_pushed++;
            m_seen = 8'h00;
        end
    endtask

    // One scan slot; model is updated at slot start so the expectation precedes frame_valid
    task automatic scan_digit(input int d, input logic [6:0] p, input logic dpb, input int len);
        sel = ~(8'h01 << d);
        seg = {~dpb, p};
        model_sample(d, p, dpb);
        repeat (len) @(negedge clk);
    endtask

    task automatic idle(input int len);
        sel = 8'hFF; seg = 8'hFF;
        repeat (len) @(negedge clk);
    endtask

    task automatic scan_frame(input logic [31:0] codes, input logic [7:0] dps, input int len,
                              input int bad_digit);
        logic [3:0] c;
        for (int d = 7; d >= 0; d--) begin
            c = codes[4*d +: 4];
            if (d == bad_digit) scan_digit(d, 7'h7E, dps[d], len);
            else                scan_digit(d, pat_tab[c], dps[d], len);
        end
    endtask

    function automatic logic [31:0] rand_codes();
        logic [31:0] r;
        for (int j = 0; j < 8; j++) r[4*j +: 4] = 4'($urandom_range(10));
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor: pops one expectation per frame_valid pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (timeout) begin
                n_tmo++;
                if (n_tmo == 1) tmo_cyc = cyc;
                $display("timeout pulse at cycle %0d", cyc);
            end
            if (frame_valid) begin
                exp_t e;
                n_frames++;
                $display("frame %0d bits=%h dp=%h seg_err=%0b", n_frames, all_bits, dp, seg_err);
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'(n_frames), 32'(n_pushed));
                end else begin
                    e = exp_q.pop_front();
                    check("frame_bits", all_bits, e.bits);
                    check("frame_dp", {24'h0, dp}, {24'h0, e.dp});
                    check("frame_seg_err", {31'h0, seg_err}, {31'h0, e.err});
                    check("frame_no_timeout", {31'h0, timeout}, 32'h0);
`ifdef CASEG_TIME_DECODE_EN
                    check("hour", {26'h0, hour}, 32'(e.h));
                    check("minute", {26'h0, minute}, 32'(e.m));
                    check("second", {26'h0, second}, 32'(e.s));
                    check("time_err", {31'h0, time_err}, {31'h0, e.terr});
`endif
                end
            end
        end
    end

    initial begin
        logic [31:0] codes;
        logic [7:0]  dps;
        int          len;
        logic [6:0]  p;
        model_reset();
        repeat (4) @(negedge clk);
        check("rst_bits", all_bits, 32'hAAAA_AAAA);
        check("rst_dp", {24'h0, dp}, 32'h0);
        check("rst_frame_valid", {31'h0, frame_valid}, 32'h0);
        check("rst_seg_err", {31'h0, seg_err}, 32'h0);
        check("rst_timeout", {31'h0, timeout}, 32'h0);
        rst = 1'b0;

        // Partial scan of digits 0..5 must end in a timeout with outputs untouched
        for (int d = 0; d < 6; d++) scan_digit(d, pat_tab[d], 1'b0, 50);
        idle(720);
        m_seen = 8'h00;
        check("timeout_count", 32'(n_tmo), 32'd1);
        check("timeout_cycle", 32'(tmo_cyc), TMO - 1);
        check("tmo_bits_hold", all_bits, 32'hAAAA_AAAA);
        check("tmo_dp_hold", {24'h0, dp}, 32'h0);
        check("tmo_no_frame", 32'(n_frames), 32'd0);

        // 12:34:56 with blank leading digits
        scan_frame(32'hAA12_3456, 8'h00, 50, -1);
        idle(10);
        check("t1_bit_5", {28'h0, bit_5}, 32'd1);
        check("t1_bit_0", {28'h0, bit_0}, 32'd6);
        check("t1_bit_7", {28'h0, bit_7}, 32'hA);
        check("t1_frames", 32'(n_frames), 32'd1);

        // Two digits low held for 100 cycles in mid-frame: no sample, mask kept
        codes = rand_codes(); dps = 8'($urandom);
        for (int d = 0; d < 4; d++) scan_digit(d, pat_tab[codes[4*d +: 4]], dps[d], 30);
        sel = 8'hFC; seg = 8'h79;
        repeat (100) @(negedge clk);
        for (int d = 4; d < 8; d++) scan_digit(d, pat_tab[codes[4*d +: 4]], dps[d], 30);

        // Glitch on digit 2: alternating invalid/valid every 2 cycles must not sample
        codes = rand_codes(); dps = 8'($urandom);
        for (int d = 0; d < 2; d++) scan_digit(d, pat_tab[codes[4*d +: 4]], dps[d], 30);
        sel = ~8'h04;
        for (int k = 0; k < 5; k++) begin
            seg = {~dps[2], (k % 2 == 0) ? 7'h7E : pat_tab[codes[11:8]]};
            repeat (2) @(negedge clk);
        end
        for (int d = 2; d < 8; d++) scan_digit(d, pat_tab[codes[4*d +: 4]], dps[d], 30);

        // Time frames, then an unrecognised pattern on digit 3
        scan_frame(32'hAA23_5959, 8'h14, 30, -1);
        scan_frame(32'hAA24_0000, 8'h00, 30, -1);
        scan_frame(rand_codes(), 8'($urandom), 30, 3);
        idle(10);
        check("t5_bit_3", {28'h0, bit_3}, 32'hF);
        check("t5_seg_err", {31'h0, seg_err}, 32'h1);

        for (int f = 0; f < 15; f++) begin
            for (int d = 7; d >= 0; d--) begin
                len = $urandom_range(8, 40);
                p = ($urandom_range(9) == 0) ? 7'($urandom) : pat_tab[$urandom_range(10)];
                scan_digit(d, p, 1'($urandom), len);
            end
        end
        idle(20);
        check("sticky_seg_err", {31'h0, seg_err}, 32'h1);

        // Reset in mid-frame drops the partial capture
        for (int d = 0; d < 4; d++) scan_digit(d, pat_tab[d + 1], 1'b1, 30);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        check("mid_rst_bits", all_bits, 32'hAAAA_AAAA);
        check("mid_rst_seg_err", {31'h0, seg_err}, 32'h0);
        rst = 1'b0;
        for (int d = 4; d < 8; d++) scan_digit(d, pat_tab[d], 1'b0, 30);
        scan_frame(rand_codes(), 8'($urandom), 30, -1);
        idle(20);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("frame_total", 32'(n_frames), 32'(n_pushed));
        check("final_timeouts", 32'(n_tmo), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
